// File: rtl/bus_arbiter_pkg.sv
// duck_bus_pkg: shared types and constants for the CPU memory bus arbiter.
//   ADDR_W / DATA_W   : bus widths (16-bit address, 8-bit data)
//   ERR_DATA_DEFAULT  : read data returned when a transaction is aborted
//   arb_state_t       : arbiter FSM states
//   master_idx_t      : index of a requesting master (0 = CPU, 1 = DMA/debug)
//   pick_master()     : round-robin choice between the two requesters
package duck_bus_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 8;
    localparam logic [DATA_W-1:0] ERR_DATA_DEFAULT = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } arb_state_t;

    typedef logic master_idx_t;

    // With both masters requesting, the one that did not win last time goes.
    function automatic master_idx_t pick_master(input logic req0,
                                                input logic req1,
                                                input master_idx_t last);
        if (req0 && req1) return ~last;
        if (req1)         return 1'b1;
        return 1'b0;
    endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: bundles the two master request ports and the shared slave
// bus of the arbiter.
//   m0_* / m1_* : per-master address, write data, read/write request levels,
//                 returned read data and 1-cycle completion pulse
//   s_*         : shared slave bus (address, write data, strobes, read data,
//                 ready)
//   bus_error   : 1-cycle pulse when a transaction times out
// Modports:
//   master : the arbiter itself -- it owns (masters) the shared slave bus
//   slave  : the surrounding system (requesting masters and the slave device)
interface bus_arbiter_if;
    import duck_bus_pkg::*;

    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_read;
    logic              m0_write;
    logic [DATA_W-1:0] m0_rdata;
    logic              m0_done;

    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_read;
    logic              m1_write;
    logic [DATA_W-1:0] m1_rdata;
    logic              m1_done;

    logic [ADDR_W-1:0] s_addr;
    logic [DATA_W-1:0] s_wdata;
    logic              s_read;
    logic              s_write;
    logic [DATA_W-1:0] s_rdata;
    logic              s_ready;

    logic              bus_error;

    modport master (
        input  m0_addr, m0_wdata, m0_read, m0_write,
        output m0_rdata, m0_done,
        input  m1_addr, m1_wdata, m1_read, m1_write,
        output m1_rdata, m1_done,
        output s_addr, s_wdata, s_read, s_write,
        input  s_rdata, s_ready,
        output bus_error
    );

    modport slave (
        output m0_addr, m0_wdata, m0_read, m0_write,
        input  m0_rdata, m0_done,
        output m1_addr, m1_wdata, m1_read, m1_write,
        input  m1_rdata, m1_done,
        input  s_addr, s_wdata, s_read, s_write,
        output s_rdata, s_ready,
        input  bus_error
    );

endinterface

// File: rtl/bus_arbiter_timeout_counter.sv
// bus_timeout_counter: counts cycles a slave strobe has gone unanswered.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : synchronous clear to zero (takes priority over enable)
//   enable     : increment by one
//   expired    : count has reached TIMEOUT-1
module bus_timeout_counter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [7:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 8'd1;
        end
    end

    assign expired = (count == 8'(TIMEOUT - 1));

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master, one-slave round-robin arbiter for the CPU memory
// bus. Grants the shared slave bus, returns read data and a per-master done
// pulse, and aborts strobes the slave never answers.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : bus_arbiter_if.master (master ports, slave bus, bus_error)
// Parameters:
//   TIMEOUT  : strobe cycles without s_ready before abort (1..255)
//   ERR_DATA : read data returned on an aborted read
module bus_arbiter
    import duck_bus_pkg::*;
#(
    parameter int unsigned       TIMEOUT  = 16,
    parameter logic [DATA_W-1:0] ERR_DATA = ERR_DATA_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    bus_arbiter_if.master bus
);

    arb_state_t        state_q, state_d;
    master_idx_t       last_q, last_d;
    logic [ADDR_W-1:0] s_addr_q, s_addr_d;
    logic [DATA_W-1:0] s_wdata_q, s_wdata_d;
    logic              s_read_q, s_read_d;
    logic              s_write_q, s_write_d;
    logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
    logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;
    logic              m0_done_q, m0_done_d;
    logic              m1_done_q, m1_done_d;
    logic              bus_error_q, bus_error_d;

    logic              req0, req1;
    master_idx_t       gnt;
    logic              finish;
    logic [DATA_W-1:0] rd_val;
    logic              cnt_clear, cnt_en, expired;

    bus_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (cnt_clear),
        .enable  (cnt_en),
        .expired (expired)
    );

    assign req0 = bus.m0_read | bus.m0_write;
    assign req1 = bus.m1_read | bus.m1_write;

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        s_addr_d    = s_addr_q;
        s_wdata_d   = s_wdata_q;
        s_read_d    = s_read_q;
        s_write_d   = s_write_q;
        m0_rdata_d  = m0_rdata_q;
        m1_rdata_d  = m1_rdata_q;
        m0_done_d   = 1'b0;
        m1_done_d   = 1'b0;
        bus_error_d = 1'b0;
        gnt         = last_q;
        finish      = 1'b0;
        rd_val      = s_rdata_mux();
        cnt_clear   = 1'b0;
        cnt_en      = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_clear = 1'b1;
                if (req0 || req1) begin
                    gnt    = pick_master(req0, req1, last_q);
                    last_d = gnt;
                    // Read wins when a master raises both read and write.
                    if (gnt) begin
                        s_addr_d  = bus.m1_addr;
                        s_wdata_d = bus.m1_wdata;
                        s_read_d  = bus.m1_read;
                        s_write_d = ~bus.m1_read;
                    end else begin
                        s_addr_d  = bus.m0_addr;
                        s_wdata_d = bus.m0_wdata;
                        s_read_d  = bus.m0_read;
                        s_write_d = ~bus.m0_read;
                    end
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // s_ready is checked first so a reply on the last allowed
                // cycle still completes normally.
                if (bus.s_ready) begin
                    finish = 1'b1;
                end else if (expired) begin
                    finish      = 1'b1;
                    rd_val      = ERR_DATA;
                    bus_error_d = 1'b1;
                end else begin
                    cnt_en = 1'b1;
                end
                if (finish) begin
                    s_read_d  = 1'b0;
                    s_write_d = 1'b0;
                    if (last_q) begin
                        m1_done_d = 1'b1;
                        if (s_read_q) m1_rdata_d = rd_val;
                    end else begin
                        m0_done_d = 1'b1;
                        if (s_read_q) m0_rdata_d = rd_val;
                    end
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    function automatic logic [DATA_W-1:0] s_rdata_mux();
        return bus.s_rdata;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            s_addr_q    <= '0;
            s_wdata_q   <= '0;
            s_read_q    <= 1'b0;
            s_write_q   <= 1'b0;
            m0_rdata_q  <= '0;
            m1_rdata_q  <= '0;
            m0_done_q   <= 1'b0;
            m1_done_q   <= 1'b0;
            bus_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            s_addr_q    <= s_addr_d;
            s_wdata_q   <= s_wdata_d;
            s_read_q    <= s_read_d;
            s_write_q   <= s_write_d;
            m0_rdata_q  <= m0_rdata_d;
            m1_rdata_q  <= m1_rdata_d;
            m0_done_q   <= m0_done_d;
            m1_done_q   <= m1_done_d;
            bus_error_q <= bus_error_d;
        end
    end

    assign bus.s_addr    = s_addr_q;
    assign bus.s_wdata   = s_wdata_q;
    assign bus.s_read    = s_read_q;
    assign bus.s_write   = s_write_q;
    assign bus.m0_rdata  = m0_rdata_q;
    assign bus.m1_rdata  = m1_rdata_q;
    assign bus.m0_done   = m0_done_q;
    assign bus.m1_done   = m1_done_q;
    assign bus.bus_error = bus_error_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: scoreboard bench for bus_arbiter. Each issued transaction
// records its slave-side plan (reply delay, reply data) keyed by address and
// pushes the expected master-side result; a slave responder and a done monitor
// compare what the DUT presents against those records.
module tb_bus_arbiter;
    import duck_bus_pkg::*;

    localparam int unsigned TO = 16;
    localparam logic [7:0]  ED = 8'hFF;

    typedef struct {
        logic       is_read;
        logic [7:0] wdata;
        int         delay;
        logic [7:0] data;
    } plan_t;

    typedef struct {
        logic [7:0] rdata;
        logic       err;
    } exp_t;

    logic clk;
    logic rst_n;

    bus_arbiter_if bus ();

    bus_arbiter #(.TIMEOUT(TO), .ERR_DATA(ED)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          checks = 0;
    int          fails  = 0;
    plan_t       plan [logic [15:0]];
    exp_t        expq0 [$];
    exp_t        expq1 [$];
    int          grant_q [$];
    logic [7:0]  model_rdata [2];
    logic        reset_test = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // Slave model: answers each strobe after its planned delay and checks the
    // strobe kind, payload, grant order and strobe length.
    logic        prev_strobe = 1'b0;
    logic [15:0] cur_addr;
    plan_t       cur;
    int          cnt = 0;

    always @(negedge clk) begin
        logic strobe;
        strobe = bus.s_read | bus.s_write;
        if (strobe && !prev_strobe) begin
            cur_addr = bus.s_addr;
            cnt      = 0;
            check("strobe_addr_known", {31'd0, plan.exists(bus.s_addr)}, 1);
            if (plan.exists(bus.s_addr)) begin
                cur = plan[bus.s_addr];
                check("s_read", {31'd0, bus.s_read}, {31'd0, cur.is_read});
                check("s_write", {31'd0, bus.s_write}, {31'd0, !cur.is_read});
                if (!cur.is_read) check("s_wdata", {24'd0, bus.s_wdata}, {24'd0, cur.wdata});
            end else begin
                cur.delay = 1000;
                cur.data  = 8'h00;
            end
            if (grant_q.size() > 0) begin
                int g;
                g = grant_q.pop_front();
                check("grant_order", {31'd0, bus.s_addr[15]}, g);
            end
        end
        if (!strobe && prev_strobe) begin
            if (!reset_test)
                check("strobe_len", cnt, (cur.delay + 1 < int'(TO)) ? cur.delay + 1 : int'(TO));
            if (plan.exists(cur_addr)) plan.delete(cur_addr);
        end
        if (strobe) begin
            check("s_addr_stable", {16'd0, bus.s_addr}, {16'd0, cur_addr});
            bus.s_ready = (cnt == cur.delay);
            bus.s_rdata = (cnt == cur.delay) ? cur.data : 8'($urandom);
            cnt++;
        end else begin
            bus.s_ready = 1'($urandom_range(0, 1));
            bus.s_rdata = 8'($urandom);
        end
        prev_strobe = strobe;
    end

    // Done monitor: every completion must match the oldest expectation for
    // that master.
    always @(negedge clk) begin
        exp_t e;
        if (bus.m0_done) begin
            check("m0_done_expected", {31'd0, expq0.size() != 0}, 1);
            if (expq0.size() != 0) begin
                e = expq0.pop_front();
                check("m0_rdata", {24'd0, bus.m0_rdata}, {24'd0, e.rdata});
                check("m0_bus_error", {31'd0, bus.bus_error}, {31'd0, e.err});
            end
        end
        if (bus.m1_done) begin
            check("m1_done_expected", {31'd0, expq1.size() != 0}, 1);
            if (expq1.size() != 0) begin
                e = expq1.pop_front();
                check("m1_rdata", {24'd0, bus.m1_rdata}, {24'd0, e.rdata});
                check("m1_bus_error", {31'd0, bus.bus_error}, {31'd0, e.err});
            end
        end
        if (bus.m0_done || bus.m1_done)
            check("done_exclusive", {31'd0, bus.m0_done & bus.m1_done}, 0);
        if (bus.bus_error)
            check("error_with_done", {31'd0, bus.m0_done | bus.m1_done}, 1);
    end

    task automatic run_txn(input int m, input logic [15:0] addr, input logic rd,
                           input logic wr, input logic [7:0] wd, input int dly,
                           input logic [7:0] sd);
        plan_t p;
        exp_t  e;
        logic  seen;
        p.is_read = rd;
        p.wdata   = wd;
        p.delay   = dly;
        p.data    = sd;
        plan[addr] = p;
        e.err   = (dly >= int'(TO));
        e.rdata = rd ? (e.err ? ED : sd) : model_rdata[m];
        if (rd) model_rdata[m] = e.rdata;
        if (m == 0) begin
            expq0.push_back(e);
            bus.m0_addr = addr; bus.m0_wdata = wd; bus.m0_read = rd; bus.m0_write = wr;
        end else begin
            expq1.push_back(e);
            bus.m1_addr = addr; bus.m1_wdata = wd; bus.m1_read = rd; bus.m1_write = wr;
        end
        seen = 1'b0;
        for (int i = 0; i < int'(TO) + 60 && !seen; i++) begin
            @(negedge clk);
            seen = (m == 0) ? bus.m0_done : bus.m1_done;
        end
        check("done_within_bound", {31'd0, seen}, 1);
        if (m == 0) begin
            bus.m0_read = 1'b0; bus.m0_write = 1'b0;
        end else begin
            bus.m1_read = 1'b0; bus.m1_write = 1'b0;
        end
    endtask

    task automatic random_master(input int m, input int n);
        for (int i = 0; i < n; i++) begin
            int          kind, dly;
            logic [14:0] lo;
            kind = int'($urandom_range(0, 2));
            dly  = ($urandom_range(0, 9) < 7) ? int'($urandom_range(0, 4))
                                               : int'($urandom_range(14, 17));
            lo   = 15'($urandom);
            run_txn(m, {(m == 1), lo}, kind != 1, kind != 0, 8'($urandom), dly,
                    8'($urandom));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic seen;
        rst_n = 1'b1;
        bus.m0_addr = '0; bus.m0_wdata = '0; bus.m0_read = 1'b0; bus.m0_write = 1'b0;
        bus.m1_addr = '0; bus.m1_wdata = '0; bus.m1_read = 1'b0; bus.m1_write = 1'b0;
        model_rdata[0] = 8'h00;
        model_rdata[1] = 8'h00;
        #2 rst_n = 1'b0;
        #4;
        check("rst_s_addr", {16'd0, bus.s_addr}, 0);
        check("rst_s_read", {31'd0, bus.s_read}, 0);
        check("rst_s_write", {31'd0, bus.s_write}, 0);
        check("rst_m0_rdata", {24'd0, bus.m0_rdata}, 0);
        check("rst_m1_rdata", {24'd0, bus.m1_rdata}, 0);
        check("rst_dones", {30'd0, bus.m0_done, bus.m1_done}, 0);
        check("rst_bus_error", {31'd0, bus.bus_error}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed transactions.
        run_txn(0, 16'h0001, 1'b1, 1'b0, 8'h00, 1, 8'h55);
        run_txn(1, 16'h8002, 1'b1, 1'b0, 8'h00, 2, 8'h77);
        run_txn(1, 16'hC000, 1'b0, 1'b1, 8'hA5, 0, 8'h00);
        run_txn(0, 16'h0010, 1'b1, 1'b0, 8'h00, 200, 8'h12);
        run_txn(0, 16'h0011, 1'b1, 1'b0, 8'h00, 15, 8'h9C);
        run_txn(1, 16'h8100, 1'b0, 1'b1, 8'h5A, 16, 8'h00);
        run_txn(0, 16'h0020, 1'b1, 1'b1, 8'hC3, 0, 8'h3E);

        // Reset in the middle of a strobe: strobe drops at once, no done.
        reset_test = 1'b1;
        plan[16'h0100] = '{is_read: 1'b1, wdata: 8'h00, delay: 1000, data: 8'h00};
        bus.m0_addr = 16'h0100;
        bus.m0_read = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = bus.s_read;
        end
        check("rst_test_strobe_seen", {31'd0, seen}, 1);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_s_read", {31'd0, bus.s_read}, 0);
        check("rst_mid_s_write", {31'd0, bus.s_write}, 0);
        check("rst_mid_m0_rdata", {24'd0, bus.m0_rdata}, 0);
        bus.m0_read = 1'b0;
        model_rdata[0] = 8'h00;
        model_rdata[1] = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        reset_test = 1'b0;

        // Contention: both read back to back, grants must alternate from 0.
        for (int i = 0; i < 4; i++) begin
            grant_q.push_back(0);
            grant_q.push_back(1);
        end
        fork
            begin
                for (int i = 0; i < 4; i++)
                    run_txn(0, 16'h0200 + 16'(i), 1'b1, 1'b0, 8'h00, 0, 8'(8'h10 + i));
            end
            begin
                for (int i = 0; i < 4; i++)
                    run_txn(1, 16'h8200 + 16'(i), 1'b1, 1'b0, 8'h00, 0, 8'(8'h20 + i));
            end
        join
        check("contention_grants_consumed", grant_q.size(), 0);

        // Randomised traffic from both masters.
        fork
            random_master(0, 25);
            random_master(1, 25);
        join

        repeat (10) @(negedge clk);
        check("expq0_empty", expq0.size(), 0);
        check("expq1_empty", expq1.size(), 0);
        check("plan_empty", plan.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
Two-master, one-slave arbiter for the 16-bit-address / 8-bit-data CPU memory bus. Master 0 is the CPU core; master 1 is a secondary requester (DMA/debug loader). The block owns the shared slave bus, grants it round-robin, returns read data and a per-master completion, and aborts transactions the slave never answers.

Parameters:
TIMEOUT, 16, cycles of slave strobe without s_ready before abort (1..255)
ERR_DATA, 8'hFF, read data returned on timeout

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
m0_addr  input  16  master 0 address, held until m0_done
m0_wdata  input  8  master 0 write data
m0_read  input  1  master 0 read request (level)
m0_write  input  1  master 0 write request (level)
m0_rdata  output  8  master 0 read data, valid with m0_done
m0_done  output  1  master 0 completion, 1-cycle pulse (CPU bus_wait = !m0_done)
m1_addr, m1_wdata, m1_read, m1_write, m1_rdata, m1_done  as master 0, for master 1
s_addr  output  16  slave address
s_wdata  output  8  slave write data
s_read  output  1  slave read strobe
s_write  output  1  slave write strobe
s_rdata  input  8  slave read data, sampled when s_ready=1
s_ready  input  1  slave completes current strobe
bus_error  output  1  1-cycle pulse on timeout abort

Behaviour:
- All outputs registered. Reset (async, rst_n=0): state=IDLE, s_addr=0, s_wdata=0, s_read=0, s_write=0, m*_rdata=0, m*_done=0, bus_error=0, timeout count=0, last_grant=1 (master 0 wins first tie).
- States: IDLE, BUSY, DONE.
- IDLE: request = read|write. If none, stay. If one, grant it. If both, grant the master != last_grant. On grant: latch addr/wdata to s_*, assert s_read (if read) else s_write, set last_grant, clear count, -> BUSY. Strobe visible cycle after request first sampled.
- Master asserting read and write together: read wins, write ignored.
- BUSY: strobes held. If s_ready=1: latch s_rdata into granted m*_rdata (reads only; writes leave rdata unchanged), pulse granted m*_done next cycle, drop strobes, -> DONE. Else count+1; when count reaches TIMEOUT-1 with s_ready=0: drop strobes, rdata=ERR_DATA (reads), pulse m*_done and bus_error together, -> DONE. s_ready on the TIMEOUT-th cycle counts as normal completion.
- DONE: one idle bus cycle (strobes low, done pulse visible) -> IDLE. Guarantees master deasserts/changes request before re-arbitration. Minimum transaction: 3 cycles request-to-done, 4 cycles request-to-next-strobe.
- Non-granted master's done never pulses; its request stays pending and wins next IDLE (round-robin, no starvation).
- Master dropping request mid-BUSY: transaction completes normally, done still pulses.
- s_ready while in IDLE/DONE: ignored.
- Reset mid-transaction: strobes drop immediately, no done pulse.

Decomposition:
- Package duck_bus_pkg: state enum (IDLE/BUSY/DONE), ADDR_W=16, DATA_W=8, master index type, ERR_DATA default.
- Sub-module bus_timeout_counter (clear, enable, expired output, TIMEOUT parameter); rest inline.

Test Plan:
- Reset: assert rst_n=0 mid-BUSY -> s_read/s_write=0 same edge, no m*_done, first grant after reset to master 0.
- Single read: m0_read, m0_addr=16'h0001, slave s_ready on 2nd strobe cycle with s_rdata=8'h55 -> m0_rdata=8'h55, m0_done 1 cycle, bus_error=0.
- Write: m1_write, m1_addr=16'hC000, m1_wdata=8'hA5 -> s_write=1, s_addr=16'hC000, s_wdata=8'hA5; m1_done pulses; m1_rdata unchanged.
- Contention: both read continuously, slave always ready -> grants alternate 0,1,0,1; each done every 4 cycles per pair-slot, none starved.
- Timeout: m0_read, s_ready held 0 -> strobe drops after 16 cycles; m0_rdata=8'hFF, m0_done and bus_error pulse same cycle; s_ready=1 on cycle 16 instead -> normal completion.
- Read+write both set on m0 with s_rdata=8'h3E -> only s_read asserted, m0_rdata=8'h3E.
